ssd_debug_display: RTL and testbench

//  Board-level debug display controller for the pipelined CPU top level.
//  - Debounces the manual step button into a one-cycle step_pulse that advances the CPU.
//  - Selects PC or register-file read data, pages through a DATA_W-bit value one
//    NUM_DIGITS-hex-digit window at a time, and time-multiplexes a common-anode

---
 rtl/ssd_debug_display_if.sv | 40 ++++
 rtl/ssd_debug_display.sv | 184 ++++++++++++++++++
 tb/tb_ssd_debug_display.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_debug_display_if.sv
// ssd_debug_display_if
//   Bundles the button, data and display signals of the debug display controller.
//   The parameters must match those of the ssd_debug_display instance it connects to.
//   master : board/CPU side (drives buttons, select and data; receives display outputs)
//   slave  : controller side
//   Signals:
//     step_btn, page_btn  raw asynchronous push-buttons
//     sel_pc              1 selects data_pc, 0 selects data_reg
//     data_pc, data_reg   DATA_W-bit words to display
//     step_pulse          one-cycle pulse per accepted step press
//     page                current page index (PW bits)
//     seg                 segments, seg[0]=a .. seg[6]=g
//     an                  one-hot digit enables, an[0] = rightmost digit
interface ssd_debug_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 32
);
  localparam int PAGES = DATA_W / (4 * NUM_DIGITS);
  localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1;

  logic                  step_btn;
  logic                  page_btn;
  logic                  sel_pc;
  logic [DATA_W-1:0]     data_pc;
  logic [DATA_W-1:0]     data_reg;
  logic                  step_pulse;
  logic [PW-1:0]         page;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;

  modport master (
    output step_btn, page_btn, sel_pc, data_pc, data_reg,
    input  step_pulse, page, seg, an
  );

  modport slave (
    input  step_btn, page_btn, sel_pc, data_pc, data_reg,
    output step_pulse, page, seg, an
  );
endinterface

// File: rtl/ssd_debug_display.sv
// ssd_debug_display
//   Debug display controller for the pipelined CPU board top level.
//   Debounces the step and page buttons, pages through a DATA_W-bit word one
//   NUM_DIGITS-hex-digit window at a time and time-multiplexes a seven-segment
//   display. The displayed word is captured once per scan frame (and on every
//   page change) so a frame never mixes nibbles of two different words.
//   Ports:
//     clk    board clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    ssd_debug_display_if.slave (buttons, select, data, display outputs)
module ssd_debug_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int DATA_W       = 32,
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ssd_debug_display_if.slave    bus
);
  localparam int PAGES = DATA_W / (4 * NUM_DIGITS);
  localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW    = $clog2(SCAN_DIV);
  localparam int CW    = $clog2(DEBOUNCE_CYC);

  localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                : {NUM_DIGITS{1'b0}};

  // Active-high gfedcba hex font.
  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Button debouncers, bit 0 = step, bit 1 = page
  // ---------------------------------------------------------------------------
  logic [1:0]    w_btn_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_deb;
  logic [CW-1:0] r_db_cnt [2];
  logic [1:0]    w_db_done;
  logic [1:0]    w_rise;

  assign w_btn_raw = {bus.page_btn, bus.step_btn};

  // The counter holds the number of consecutive synchronised samples that
  // disagree with the accepted level; the D-th one flips the level.
  for (genvar gi = 0; gi < 2; gi++) begin : g_db
    assign w_db_done[gi] = (r_sync2[gi] != r_deb[gi]) &&
                           (r_db_cnt[gi] == CW'(DEBOUNCE_CYC - 1));
    assign w_rise[gi]    = w_db_done[gi] && r_sync2[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_db_done[i]) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Step pulse and page counter
  // ---------------------------------------------------------------------------
  logic          r_step_pulse;
  logic [PW-1:0] r_page;
  logic          w_page_inc;

  // With a single page the counter never moves and never triggers a relatch.
  assign w_page_inc = (PAGES > 1) && w_rise[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_pulse <= 1'b0;
      r_page       <= '0;
    end else begin
      r_step_pulse <= w_rise[0];
      if (w_page_inc) begin
        r_page <= (r_page == PW'(PAGES - 1)) ? '0 : r_page + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan prescaler, digit index and frame latch
  // ---------------------------------------------------------------------------
  logic [SW-1:0]     r_presc;
  logic [DW-1:0]     r_d;
  logic              r_scan_on;
  logic [DATA_W-1:0] r_frame;
  logic              w_tc;
  logic              w_wrap;

  // The first terminal count after reset counts as a wrap so the display
  // starts on digit 0 with a freshly latched frame.
  assign w_tc   = (r_presc == SW'(SCAN_DIV - 1));
  assign w_wrap = w_tc && (!r_scan_on || (r_d == DW'(NUM_DIGITS - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_d       <= '0;
      r_scan_on <= 1'b0;
      r_frame   <= '0;
    end else begin
      r_presc <= w_tc ? '0 : r_presc + 1'b1;
      if (w_tc) begin
        r_scan_on <= 1'b1;
        r_d       <= w_wrap ? '0 : r_d + 1'b1;
      end
      if (w_wrap || w_page_inc) begin
        r_frame <= bus.sel_pc ? bus.data_pc : bus.data_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered segment / anode drive
  // ---------------------------------------------------------------------------
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg_on;
  logic [NUM_DIGITS-1:0] w_an_on;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  assign w_nibble = r_frame[4 * (int'(r_page) * NUM_DIGITS + int'(r_d)) +: 4];
  assign w_seg_on = hex_font(w_nibble);

  always_comb begin
    w_an_on      = '0;
    w_an_on[r_d] = 1'b1;
  end

  // Outputs stay blank until the first digit slot starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
    end else if (r_scan_on) begin
      r_seg <= (ACTIVE_LOW != 0) ? ~w_seg_on : w_seg_on;
      r_an  <= (ACTIVE_LOW != 0) ? ~w_an_on  : w_an_on;
    end
  end

  assign bus.step_pulse = r_step_pulse;
  assign bus.page       = r_page;
  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
endmodule

// File: tb/tb_ssd_debug_display.sv
// tb_ssd_debug_display
//   Self-checking bench for ssd_debug_display with a small scan divider and
//   debounce length. A behavioural model predicts step pulses, page changes
//   and digit updates into queues; a monitor pops them as the DUT produces them.
module tb_ssd_debug_display;
  localparam int NUM_DIGITS   = 4;
  localparam int DATA_W       = 32;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CYC = 8;
  localparam int ACTIVE_LOW   = 1;
  localparam int PAGES        = DATA_W / (4 * NUM_DIGITS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ssd_debug_display_if #(.NUM_DIGITS(NUM_DIGITS), .DATA_W(DATA_W)) bus ();

  ssd_debug_display #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DATA_W      (DATA_W),
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .ACTIVE_LOW  (ACTIVE_LOW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int nCompares    = 0;
  int nMiscompares = 0;

  logic [6:0] fontTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompares++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic logMiss(input string name, input string what);
    nCompares++;
    nMiscompares++;
    $display("[TB] FAIL %s: got %s, want scheduled event", name, what);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a button level is accepted once the last DEBOUNCE_CYC
  // synchronised samples (raw input delayed by two clocks) all disagree with it.
  // Digit slots begin every SCAN_DIV clocks; slot k shows digit (k-1) mod N.
  // ---------------------------------------------------------------------------
  int           cyc;
  bit           rawHist [2][DEBOUNCE_CYC+2];
  bit           lvl [2];
  int           mPage;
  logic [31:0]  mFrame;
  logic [10:0]  expDispQ [$];
  int           expStepQ [$];
  int           expPageQ [$];

  function automatic bit settled(input int b);
    for (int k = 0; k < DEBOUNCE_CYC; k++)
      if (rawHist[b][k] == lvl[b]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int b = 0; b < 2; b++) begin
        lvl[b] = 1'b0;
        for (int k = 0; k < DEBOUNCE_CYC + 2; k++) rawHist[b][k] = 1'b0;
      end
      mPage  = 0;
      mFrame = '0;
      expDispQ.delete();
      expStepQ.delete();
      expPageQ.delete();
    end else begin
      int         digit;
      int         nib;
      logic [3:0] anExp;
      logic [6:0] segExp;
      cyc++;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < DEBOUNCE_CYC + 1; k++) rawHist[b][k] = rawHist[b][k+1];
      end
      rawHist[0][DEBOUNCE_CYC+1] = bus.step_btn;
      rawHist[1][DEBOUNCE_CYC+1] = bus.page_btn;
      for (int b = 0; b < 2; b++) begin
        if (settled(b)) begin
          lvl[b] = !lvl[b];
          if (lvl[b]) begin
            if (b == 0) begin
              expStepQ.push_back(cyc);
            end else begin
              mPage  = (mPage + 1) % PAGES;
              mFrame = bus.sel_pc ? bus.data_pc : bus.data_reg;
              expPageQ.push_back(mPage);
            end
          end
        end
      end
      if (cyc % SCAN_DIV == 0) begin
        digit = (cyc / SCAN_DIV - 1) % NUM_DIGITS;
        if (digit == 0) mFrame = bus.sel_pc ? bus.data_pc : bus.data_reg;
        nib    = int'((mFrame >> (4 * (mPage * NUM_DIGITS + digit))) & 32'hF);
        anExp  = ~(4'b0001 << digit);
        segExp = ~fontTable[nib];
        expDispQ.push_back({anExp, segExp});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: samples 1 time unit after each rising edge and retires the
  // oldest expectation whenever the DUT produces a pulse, page or digit change.
  // ---------------------------------------------------------------------------
  logic [3:0] prevAn       = 4'hF;
  logic       prevPage     = 1'b0;
  int         pulsesSeen   = 0;
  int         lastPulseCyc = -1;

  initial begin
    logic [10:0] e;
    int          s;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prevAn   = 4'hF;
        prevPage = 1'b0;
      end else begin
        if (bus.step_pulse === 1'b1) begin
          pulsesSeen++;
          lastPulseCyc = cyc;
          if (expStepQ.size() == 0) begin
            logMiss("step_pulse", "unscheduled pulse");
          end else begin
            s = expStepQ.pop_front();
            checkOutput("step_pulse cycle", cyc, s);
          end
        end
        if (bus.page !== prevPage) begin
          if (expPageQ.size() == 0) begin
            logMiss("page change", "unscheduled change");
          end else begin
            s = expPageQ.pop_front();
            checkOutput("page value", bus.page, s);
          end
          prevPage = bus.page;
        end
        if (bus.an !== prevAn) begin
          if (expDispQ.size() == 0) begin
            logMiss("digit change", "unscheduled change");
          end else begin
            e = expDispQ.pop_front();
            checkOutput("digit an", bus.an, e[10:7]);
            checkOutput("digit seg", bus.seg, e[6:0]);
          end
          prevAn = bus.an;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  bit churn = 1'b0;

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      if (churn && ($urandom_range(0, 7) == 0)) begin
        bus.data_pc  = $urandom;
        bus.data_reg = $urandom;
        bus.sel_pc   = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic driveBtn(input int which, input logic v);
    if (which != 1) bus.step_btn = v;
    if (which != 0) bus.page_btn = v;
  endtask

  // which: 0 step, 1 page, 2 both
  task automatic pressButton(input int which, input int nBounce);
    for (int i = 0; i < nBounce; i++) begin
      driveBtn(which, logic'(i % 2 == 0));
      applyStimulus($urandom_range(1, DEBOUNCE_CYC + 1));
    end
    driveBtn(which, 1'b1);
    applyStimulus(DEBOUNCE_CYC + 4 + $urandom_range(0, 6));
    for (int i = 0; i < nBounce; i++) begin
      driveBtn(which, logic'(i % 2 == 1));
      applyStimulus($urandom_range(1, DEBOUNCE_CYC - 2));
    end
    driveBtn(which, 1'b0);
    applyStimulus(DEBOUNCE_CYC + 4 + $urandom_range(0, 6));
  endtask

  task automatic waitForAn(input logic [3:0] want, output int waited);
    waited = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.an === want) begin
        waited = i + 1;
        return;
      end
    end
    logMiss("wait for an", "timeout");
  endtask

  initial begin
    int w;
    int base;
    int holdCyc;

    bus.step_btn = 1'b0;
    bus.page_btn = 1'b0;
    bus.sel_pc   = 1'b0;
    bus.data_pc  = '0;
    bus.data_reg = '0;
    rst_n        = 1'b0;

    // Reset holds outputs blank whatever the inputs do.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.step_btn = 1'($urandom_range(0, 1));
      bus.page_btn = 1'($urandom_range(0, 1));
      bus.sel_pc   = 1'($urandom_range(0, 1));
      bus.data_pc  = $urandom;
      bus.data_reg = $urandom;
      #1;
      checkOutput("reset an", bus.an, 4'hF);
      checkOutput("reset seg", bus.seg, 7'h7F);
      checkOutput("reset step_pulse", bus.step_pulse, 1'b0);
      checkOutput("reset page", bus.page, 1'b0);
    end

    @(negedge clk);
    bus.step_btn = 1'b0;
    bus.page_btn = 1'b0;
    bus.sel_pc   = 1'b0;
    bus.data_reg = 32'h1234ABCD;
    bus.data_pc  = 32'h0;
    rst_n        = 1'b1;

    // Page 0 of data_reg: d, C, b, A with SCAN_DIV-cycle dwell.
    waitForAn(4'b1110, w);
    checkOutput("p0 digit0 seg", bus.seg, 7'h21);
    waitForAn(4'b1101, w);
    checkOutput("p0 digit1 seg", bus.seg, 7'h46);
    checkOutput("digit dwell", w, SCAN_DIV);
    waitForAn(4'b1011, w);
    checkOutput("p0 digit2 seg", bus.seg, 7'h03);
    waitForAn(4'b0111, w);
    checkOutput("p0 digit3 seg", bus.seg, 7'h08);

    // Bouncing step button, then a long hold and a release.
    @(negedge clk);
    base = pulsesSeen;
    for (int i = 0; i < 10; i++) begin
      bus.step_btn = ~bus.step_btn;
      applyStimulus(3);
    end
    bus.step_btn = 1'b1;
    holdCyc      = cyc;
    applyStimulus(40);
    bus.step_btn = 1'b0;
    applyStimulus(20);
    checkOutput("step pulse count", pulsesSeen - base, 1);
    checkOutput("step latency", lastPulseCyc - holdCyc, DEBOUNCE_CYC + 2);

    // Page press moves to page 1 (digits 4,3,2,1), second press wraps to 0.
    pressButton(1, 0);
    checkOutput("page after press", bus.page, 1);
    waitForAn(4'b1110, w);
    checkOutput("p1 digit0 seg", bus.seg, 7'h19);
    @(negedge clk);
    pressButton(1, 0);
    checkOutput("page after wrap", bus.page, 0);

    // Source switch mid-frame takes effect only at the next frame.
    waitForAn(4'b1101, w);
    bus.sel_pc  = 1'b1;
    bus.data_pc = 32'h00400010;
    waitForAn(4'b1011, w);
    checkOutput("no tear digit2 seg", bus.seg, 7'h03);
    waitForAn(4'b1110, w);
    checkOutput("new frame digit0 seg", bus.seg, 7'h40);
    waitForAn(4'b1101, w);
    checkOutput("new frame digit1 seg", bus.seg, 7'h79);

    // Randomised presses with data churning underneath.
    @(negedge clk);
    churn = 1'b1;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0:       pressButton(0, $urandom_range(0, 4));
        1:       pressButton(1, $urandom_range(0, 4));
        2:       pressButton(2, $urandom_range(0, 2));
        default: applyStimulus($urandom_range(1, 20));
      endcase
    end
    churn = 1'b0;

    // Reset mid-scan with step held through the release.
    waitForAn(4'b1101, w);
    @(negedge clk);
    bus.step_btn = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset an", bus.an, 4'hF);
    checkOutput("mid reset seg", bus.seg, 7'h7F);
    checkOutput("mid reset step_pulse", bus.step_pulse, 1'b0);
    checkOutput("mid reset page", bus.page, 1'b0);
    applyStimulus(3);
    lastPulseCyc = -1;
    rst_n = 1'b1;
    w = -1;
    for (int i = 0; i < 50 && w < 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.an !== 4'hF) w = i;
    end
    checkOutput("restart digit", bus.an, 4'b1110);
    applyStimulus(15);
    checkOutput("pulse after reset", lastPulseCyc, DEBOUNCE_CYC + 2);
    bus.step_btn = 1'b0;
    applyStimulus(60);

    checkOutput("pending step", expStepQ.size(), 0);
    checkOutput("pending page", expPageQ.size(), 0);
    checkOutput("pending display", (expDispQ.size() <= 1) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nCompares, nMiscompares);
    $finish;
  end
endmodule
